// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: word width, fetch defaults,
// fetch state encoding and the IF/ID pipeline register layout.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC    = 16'h0000;
    localparam logic [3:0]        DEFAULT_HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus_two;
    } ifid_t;

    // The opcode lives in the top nibble of every instruction word.
    function automatic logic is_halt(input logic [WORD_W-1:0] instr,
                                     input logic [3:0]        halt_opcode);
        return instr[WORD_W-1 -: 4] == halt_opcode;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_valid;
    logic [WORD_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: instructions delivered into IF/ID and stall cycles.
// Both wrap at 2^32; the caller gates the increments so they freeze in HALT.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_inc) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall_inc) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request, one-entry skid buffer and
// IF/ID register. Define FETCH_PERF_CNT_EN to add the perf_* counter outputs.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [3:0]        HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              branch,
    input  logic [WORD_W-1:0] target_pc,
    input  logic              stall,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc_plus_two,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_HALT = HALT;

    logic [1:0]        state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus_two;
    logic              req;
    logic              transfer;
    ifid_t             ifid;
    ifid_t             skid;

    // The request is gated by rst_n so an in-flight fetch aborts the moment reset asserts.
    assign req         = rst_n && (state == ST_RUN);
    assign transfer    = req && imem.imem_valid;
    assign pc_plus_two = pc + WORD_W'(2);

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign ifid_valid       = ifid.valid;
    assign ifid_instr       = ifid.instr;
    assign ifid_pc_plus_two = ifid.pc_plus_two;
    assign halted           = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            ifid  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch) begin
                        pc         <= target_pc;
                        ifid.valid <= 1'b0;
                    end else if (transfer && !stall) begin
                        ifid.valid       <= 1'b1;
                        ifid.instr       <= imem.imem_rdata;
                        ifid.pc_plus_two <= pc_plus_two;
                        pc               <= pc_plus_two;
                        if (is_halt(imem.imem_rdata, HALT_OPCODE)) begin
                            state <= ST_HALT;
                        end
                    end else if (transfer) begin
                        // IF/ID is held by the stall, so park the word and stop requesting.
                        skid.valid       <= 1'b1;
                        skid.instr       <= imem.imem_rdata;
                        skid.pc_plus_two <= pc_plus_two;
                        pc               <= pc_plus_two;
                        state            <= ST_HOLD;
                    end else if (!stall) begin
                        ifid.valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (branch) begin
                        pc         <= target_pc;
                        ifid.valid <= 1'b0;
                        skid.valid <= 1'b0;
                        state      <= ST_RUN;
                    end else if (!stall) begin
                        ifid       <= skid;
                        skid.valid <= 1'b0;
                        state      <= is_halt(skid.instr, HALT_OPCODE) ? ST_HALT : ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    // Exactly the two paths above that write a real instruction into IF/ID.
    assign fetch_inc = !branch && !stall &&
                       (((state == ST_RUN) && transfer) || (state == ST_HOLD));
    assign stall_inc = stall && (state != ST_HALT);

    fetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_inc      (fetch_inc),
        .stall_inc      (stall_inc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, a queue-based model
// compared every cycle, and hand-computed literal checks.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        branch    = 1'b0;
    logic        stall     = 1'b0;
    logic [15:0] target_pc = 16'h0000;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus_two;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage_if imem_bus ();

    int vecCount  = 0;
    int failCount = 0;

    logic [15:0] memOverride [logic [15:0]];
    int          memGen = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem_bus),
        .branch           (branch),
        .target_pc        (target_pc),
        .stall            (stall),
        .ifid_valid       (ifid_valid),
        .ifid_instr       (ifid_instr),
        .ifid_pc_plus_two (ifid_pc_plus_two),
        .halted           (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    // Memory contents: opcode 1 plus the low address bits, unless overridden.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        if (memOverride.exists(a)) return memOverride[a];
        return {4'h1, a[11:0]};
    endfunction

    always @(imem_bus.imem_addr, memGen) imem_bus.imem_rdata = memWord(imem_bus.imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: fetch stops when halted or when a fetched word is waiting in the queue.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } fetched_t;

    fetched_t    pending[$];
    fetched_t    f;
    logic [15:0] w;
    logic [15:0] mPc;
    bit          mHalted;
    logic        mValid;
    logic [15:0] mInstr;
    logic [15:0] mPcp2;
    logic [31:0] mFetchCnt;
    logic [31:0] mStallCnt;

    task automatic deliver(input logic [15:0] instr, input logic [15:0] pcp2);
        mValid    = 1'b1;
        mInstr    = instr;
        mPcp2     = pcp2;
        mHalted   = (instr[15:12] == 4'hF);
        mFetchCnt = mFetchCnt + 32'd1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending.delete();
            mPc       = 16'h0000;
            mHalted   = 1'b0;
            mValid    = 1'b0;
            mInstr    = 16'h0000;
            mPcp2     = 16'h0000;
            mFetchCnt = 32'd0;
            mStallCnt = 32'd0;
        end else if (!mHalted) begin
            if (stall) mStallCnt = mStallCnt + 32'd1;
            if (branch) begin
                mPc    = target_pc;
                mValid = 1'b0;
                pending.delete();
            end else if (pending.size() != 0) begin
                if (!stall) begin
                    f = pending.pop_front();
                    deliver(f.instr, f.pcp2);
                end
            end else if (imem_bus.imem_valid) begin
                w = memWord(mPc);
                if (stall) pending.push_back('{w, mPc + 16'd2});
                else deliver(w, mPc + 16'd2);
                mPc = mPc + 16'd2;
            end else if (!stall) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_imem_req", 32'(imem_bus.imem_req),
                    32'(rst_n && !mHalted && pending.size() == 0));
        checkOutput("cyc_imem_addr", 32'(imem_bus.imem_addr), 32'(mPc));
        checkOutput("cyc_ifid_valid", 32'(ifid_valid), 32'(mValid));
        checkOutput("cyc_ifid_instr", 32'(ifid_instr), 32'(mInstr));
        checkOutput("cyc_ifid_pc2", 32'(ifid_pc_plus_two), 32'(mPcp2));
        checkOutput("cyc_halted", 32'(halted), 32'(mHalted));
`ifdef FETCH_PERF_CNT_EN
        checkOutput("cyc_perf_fetch", perf_fetch_cnt, mFetchCnt);
        checkOutput("cyc_perf_stall", perf_stall_cnt, mStallCnt);
`endif
    end

    task automatic applyStimulus(input logic b, input logic [15:0] tgt, input logic st, input logic v);
        branch              = b;
        target_pc           = tgt;
        stall               = st;
        imem_bus.imem_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted between edges so the asynchronous request abort is visible.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n               = 1'b0;
        branch              = 1'b0;
        stall               = 1'b0;
        imem_bus.imem_valid = 1'b1;
        #1;
        checkOutput("rst_req_drop", 32'(imem_bus.imem_req), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_ifid_valid", 32'(ifid_valid), 32'h0);
        checkOutput("rst_ifid_instr", 32'(ifid_instr), 32'h0);
        checkOutput("rst_ifid_pc2", 32'(ifid_pc_plus_two), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_addr", 32'(imem_bus.imem_addr), 32'h0000);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_req", 32'(imem_bus.imem_req), 32'h1);
    endtask

    initial begin
        imem_bus.imem_valid = 1'b0;
        doReset();

        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t1_addr_a", 32'(imem_bus.imem_addr), 32'h0002);
        checkOutput("t1_valid_a", 32'(ifid_valid), 32'h1);
        checkOutput("t1_pc2_a", 32'(ifid_pc_plus_two), 32'h0002);
        checkOutput("t1_instr_a", 32'(ifid_instr), 32'h1000);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t1_addr_b", 32'(imem_bus.imem_addr), 32'h0004);
        checkOutput("t1_pc2_b", 32'(ifid_pc_plus_two), 32'h0004);
        checkOutput("t1_instr_b", 32'(ifid_instr), 32'h1002);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t1_addr_c", 32'(imem_bus.imem_addr), 32'h0006);
        checkOutput("t1_pc2_c", 32'(ifid_pc_plus_two), 32'h0006);

        doReset();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
            checkOutput("t2_addr_wait", 32'(imem_bus.imem_addr), 32'h0002);
            checkOutput("t2_bubble", 32'(ifid_valid), 32'h0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t2_valid", 32'(ifid_valid), 32'h1);
        checkOutput("t2_instr", 32'(ifid_instr), 32'h1002);
        checkOutput("t2_pc2", 32'(ifid_pc_plus_two), 32'h0004);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
            checkOutput("t3_req_hold", 32'(imem_bus.imem_req), 32'h0);
            checkOutput("t3_instr_hold", 32'(ifid_instr), 32'h1002);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t3_skid_instr", 32'(ifid_instr), 32'h1004);
        checkOutput("t3_skid_pc2", 32'(ifid_pc_plus_two), 32'h0006);
        checkOutput("t3_req_resume", 32'(imem_bus.imem_req), 32'h1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t3_next_instr", 32'(ifid_instr), 32'h1006);

        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0040, 1'b1, 1'b1);
        checkOutput("t4_addr", 32'(imem_bus.imem_addr), 32'h0040);
        checkOutput("t4_valid", 32'(ifid_valid), 32'h0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t4_instr", 32'(ifid_instr), 32'h1040);
        checkOutput("t4_pc2", 32'(ifid_pc_plus_two), 32'h0042);

        memOverride[16'hFFFE] = 16'h1234;
        memGen++;
        applyStimulus(1'b1, 16'hFFFE, 1'b0, 1'b1);
        checkOutput("t6_addr", 32'(imem_bus.imem_addr), 32'hFFFE);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t6_instr", 32'(ifid_instr), 32'h1234);
        checkOutput("t6_pc2_wrap", 32'(ifid_pc_plus_two), 32'h0000);
        checkOutput("t6_addr_wrap", 32'(imem_bus.imem_addr), 32'h0000);

        memOverride[16'h0100] = 16'hF000;
        memGen++;
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("sq_not_halted", 32'(halted), 32'h0);
        applyStimulus(1'b1, 16'h0200, 1'b1, 1'b1);
        checkOutput("sq_halted", 32'(halted), 32'h0);
        checkOutput("sq_addr", 32'(imem_bus.imem_addr), 32'h0200);

        memOverride[16'h0006] = 16'hF000;
        memGen++;
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("t5_instr", 32'(ifid_instr), 32'hF000);
        checkOutput("t5_halted", 32'(halted), 32'h1);
        checkOutput("t5_req", 32'(imem_bus.imem_req), 32'h0);
        applyStimulus(1'b1, 16'h0040, 1'b1, 1'b1);
        checkOutput("t5_addr_frozen", 32'(imem_bus.imem_addr), 32'h0008);
        checkOutput("t5_instr_frozen", 32'(ifid_instr), 32'hF000);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
